// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One MSB-first CRC-16-CCITT step over a single input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous init and enable.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises a word stream MSB-first into a CHAIN_LEN-bit configuration chain and
// controls fabric isolation. Define CCFF_TAIL_CRC_EN to add a CRC of the returning tail.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic              busy,
`ifdef CCFF_TAIL_CRC_EN
  output logic              done,
  output logic [15:0]       tail_crc
`else
  output logic              done
`endif
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int WL_W = $clog2(WORD_W + 1);

  state_t            state;
  state_t            state_next;
  logic [BL_W-1:0]   bits_left;
  logic [WL_W-1:0]   word_left;
  logic [WORD_W-1:0] sreg;
  logic              cfg_ok;
  logic              load_go;
  logic              accept;
  logic              shift_step;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_go    = 1'b0;
    accept     = 1'b0;
    shift_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          load_go    = 1'b1;
        end
      end
      FETCH: begin
        if (s_valid) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end
      end
      SHIFT: begin
        shift_step = 1'b1;
        // Decisions look at the pre-decrement counts, so "1 left" means "0 after this step".
        if (bits_left <= BL_W'(1)) begin
          state_next = DONE;
        end else if (word_left <= WL_W'(1)) begin
          state_next = FETCH;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign s_ready = (state == FETCH);
  assign busy    = (state != IDLE);
  assign isol_n  = (state == IDLE) && cfg_ok;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cfg_ok       <= 1'b0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
      done         <= 1'b0;
      bits_left    <= '0;
      word_left    <= '0;
    end else begin
      done         <= (state == DONE);
      chain_clk_en <= shift_step;
      if (shift_step) begin
        ccff_head <= sreg[WORD_W-1];
      end
      if (load_go) begin
        bits_left <= BL_W'(CHAIN_LEN);
        cfg_ok    <= 1'b0;
      end else if (state == DONE) begin
        cfg_ok <= 1'b1;
      end
      // A short final word only shifts the bits the chain still needs.
      if (accept) begin
        if (int'(bits_left) > WORD_W) begin
          word_left <= WL_W'(WORD_W);
        end else begin
          word_left <= WL_W'(bits_left);
        end
      end else if (shift_step && (word_left != '0)) begin
        word_left <= word_left - WL_W'(1);
      end
      if (shift_step && (bits_left != '0)) begin
        bits_left <= bits_left - BL_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (accept) begin
      sreg <= s_data;
    end else if (shift_step) begin
      sreg <= sreg << 1;
    end
  end

`ifdef CCFF_TAIL_CRC_EN
  ccff_crc16_serial u_crc (
    .clk  (prog_clk),
    .rst  (prog_reset),
    .init (load_go),
    .en   (chain_clk_en),
    .din  (ccff_tail),
    .crc  (tail_crc)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed scoreboard bench for ccff_bitstream_loader with 16-bit and 12-bit chains.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start16, start12;
  logic       s_valid;
  logic [7:0] s_data;

  logic rdy16, head16, en16, isol16, busy16, done16;
  logic rdy12, head12, en12, isol12, busy12, done12;

  logic [15:0] chain16 = '0;
  logic        tail16;
  assign tail16 = chain16[15];

`ifdef CCFF_TAIL_CRC_EN
  logic [15:0] crc16;
  logic [15:0] crc12;
`endif

  ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk     (clk),
    .prog_reset   (rst),
    .start        (start16),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (rdy16),
    .ccff_head    (head16),
    .chain_clk_en (en16),
    .ccff_tail    (tail16),
    .isol_n       (isol16),
    .busy         (busy16),
`ifdef CCFF_TAIL_CRC_EN
    .done         (done16),
    .tail_crc     (crc16)
`else
    .done         (done16)
`endif
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk     (clk),
    .prog_reset   (rst),
    .start        (start12),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (rdy12),
    .ccff_head    (head12),
    .chain_clk_en (en12),
    .ccff_tail    (1'b0),
    .isol_n       (isol12),
    .busy         (busy12),
`ifdef CCFF_TAIL_CRC_EN
    .done         (done12),
    .tail_crc     (crc12)
`else
    .done         (done12)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int en_cnt16 = 0, en_cnt12 = 0;
  int done_cnt16 = 0, done_cnt12 = 0;
  bit q16[$];
  bit q12[$];
  bit eb16, eb12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (en16) chain16 <= {chain16[14:0], head16};

  // Scoreboard: every enabled head bit must match the next expected bit.
  always @(negedge clk) begin
    if (en16) begin
      en_cnt16++;
      chk("q16_has_bit", (q16.size() > 0), 1);
      if (q16.size() > 0) begin
        eb16 = q16.pop_front();
        chk("head16_bit", head16, eb16);
      end
    end
    if (en12) begin
      en_cnt12++;
      chk("q12_has_bit", (q12.size() > 0), 1);
      if (q12.size() > 0) begin
        eb12 = q12.pop_front();
        chk("head12_bit", head12, eb12);
      end
    end
    if (done16) done_cnt16++;
    if (done12) done_cnt12++;
  end

  task automatic load(input int sel, input logic [7:0] w0, input logic [7:0] w1,
                      input int stall, input bit poke);
    int         len;
    int         remaining;
    int         take;
    int         budget;
    int         exp_lat;
    logic [7:0] w;
    len       = (sel != 0) ? 12 : 16;
    remaining = len;
    exp_lat   = len + (len + 7) / 8 + 2 + stall;
    if (sel != 0) begin en_cnt12 = 0; done_cnt12 = 0; end
    else begin en_cnt16 = 0; done_cnt16 = 0; end
    s_data  = w0;
    s_valid = 1'b1;
    if (sel != 0) start12 = 1'b1; else start16 = 1'b1;
    start_cyc = cyc;
    tick();
    start12 = 1'b0;
    start16 = 1'b0;
    chk("busy_after_start", (sel != 0) ? busy12 : busy16, 1);
    chk("isol_low_loading", (sel != 0) ? isol12 : isol16, 0);
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? w0 : w1;
      budget = 0;
      while (!((sel != 0) ? rdy12 : rdy16) && budget < 100) begin
        tick();
        budget++;
      end
      chk("fetch_reached", (sel != 0) ? rdy12 : rdy16, 1);
      if (i == 1 && stall > 0) begin
        s_valid = 1'b0;
        for (int k = 0; k < stall; k++) begin
          tick();
          chk("stall_no_enable", (sel != 0) ? en12 : en16, 0);
          chk("stall_still_ready", (sel != 0) ? rdy12 : rdy16, 1);
        end
        s_valid = 1'b1;
      end
      s_data = w;
      take = (remaining > 8) ? 8 : remaining;
      for (int b = 0; b < take; b++) begin
        if (sel != 0) q12.push_back(w[7-b]); else q16.push_back(w[7-b]);
      end
      remaining -= take;
      tick();
      chk("word_accepted", (sel != 0) ? rdy12 : rdy16, 0);
      if (i == 0 && poke) begin
        tick();
        tick();
        if (sel != 0) start12 = 1'b1; else start16 = 1'b1;
        tick();
        start12 = 1'b0;
        start16 = 1'b0;
      end
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
    budget  = 0;
    while (!((sel != 0) ? done12 : done16) && budget < 200) begin
      tick();
      budget++;
    end
    chk("done_seen", (sel != 0) ? done12 : done16, 1);
    chk("latency", cyc - start_cyc, exp_lat);
    chk("enable_count", (sel != 0) ? en_cnt12 : en_cnt16, len);
    chk("queue_drained", (sel != 0) ? q12.size() : q16.size(), 0);
    chk("isol_high_after_done", (sel != 0) ? isol12 : isol16, 1);
    chk("busy_low_after_done", (sel != 0) ? busy12 : busy16, 0);
    tick();
    chk("done_one_cycle", (sel != 0) ? done12 : done16, 0);
    chk("done_count", (sel != 0) ? done_cnt12 : done_cnt16, 1);
    chk("isol_holds", (sel != 0) ? isol12 : isol16, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst = 1'b1; start16 = 1'b0; start12 = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    tick();
    tick();
    chk("rst_head16", head16, 0);
    chk("rst_en16", en16, 0);
    chk("rst_ready16", rdy16, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_done16", done16, 0);
    chk("rst_isol16", isol16, 0);
    chk("rst_head12", head12, 0);
    chk("rst_en12", en12, 0);
    chk("rst_isol12", isol12, 0);
`ifdef CCFF_TAIL_CRC_EN
    chk("rst_crc16", crc16, 16'hFFFF);
`endif
    rst = 1'b0;

    // Idle ignores s_valid.
    s_valid = 1'b1;
    tick();
    tick();
    chk("idle_ready_low", rdy16, 0);
    chk("idle_busy_low", busy16, 0);
    s_valid = 1'b0;

    // Reset wins over a coincident start.
    rst = 1'b1;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    rst = 1'b0;
    tick();
    chk("start_under_reset", busy16, 0);

    load(0, 8'hA5, 8'h3C, 0, 0);
    chk("chain_content", chain16, 16'hA53C);

    load(1, 8'hFF, 8'h9F, 0, 0);

    load(0, 8'hA5, 8'h3C, 5, 0);
    chk("chain_after_stall", chain16, 16'hA53C);

    // Abort mid-load with reset.
    en_cnt16 = 0;
    s_data = 8'hA5;
    s_valid = 1'b1;
    for (int b = 0; b < 8; b++) q16.push_back(s_data[7-b]);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    budget = 0;
    while (en_cnt16 < 6 && budget < 100) begin
      tick();
      budget++;
    end
    chk("six_shifts_reached", (en_cnt16 >= 6), 1);
    rst = 1'b1;
    tick();
    chk("abort_head", head16, 0);
    chk("abort_en", en16, 0);
    chk("abort_ready", rdy16, 0);
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_isol", isol16, 0);
    rst = 1'b0;
    s_valid = 1'b0;
    q16.delete();
    tick();
    chk("abort_isol_stays", isol16, 0);

    load(0, 8'h5A, 8'hC3, 0, 0);
    chk("chain_reload", chain16, 16'h5AC3);

    load(0, 8'h96, 8'h0F, 0, 1);
    chk("chain_after_poke", chain16, 16'h960F);

`ifdef CCFF_TAIL_CRC_EN
    load(0, 8'hA5, 8'h3C, 0, 0);
    load(0, 8'hA5, 8'h3C, 0, 0);
    chk("tail_crc_readback", crc16, crc_ref(16'hA53C));
    tick();
    tick();
    chk("tail_crc_holds", crc16, crc_ref(16'hA53C));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
